// File: rtl/alu_pkg.sv
// ALU opcode map shared with ALU_control plus the execute-stage state encoding.
// No logic here; latency and backpressure live in alu_exec_unit.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared {hi,lo} shift register: shift-add multiply or restoring divide, one bit per cycle.
// Latency WIDTH steps after load; no backpressure, the parent decides when to load and run.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic [WIDTH-1:0] lo_nxt_o,
    output logic             last_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic             is_div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   sum, rem, diff;

    always_comb begin
        sum  = {1'b0, hi_q} + {1'b0, opnd_q};
        rem  = {hi_q, lo_q[WIDTH-1]};
        diff = rem - {1'b0, opnd_q};
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_div_q) begin
            // Partial remainder never reaches 2*divisor, so diff[WIDTH] is a clean borrow.
            if (!diff[WIDTH]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else if (load_i) begin
            hi_q     <= '0;
            lo_q     <= a_i;
            opnd_q   <= b_i;
            is_div_q <= is_div_i;
            cnt_q    <= '0;
        end else if (run_i) begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    assign hi_nxt_o = hi_d;
    assign lo_nxt_o = lo_d;
    assign last_o   = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops done at T+1, mult/div done at T+WIDTH+1.
// busy holds off new ops during iteration; start while busy is dropped, not queued.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] sc_res, eng_hi, eng_lo;
    logic             eng_load, eng_last;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load_i   (eng_load),
        .run_i    (state_q == ITER),
        .is_div_i (alu_op == ALU_DIV),
        .a_i      (op_a),
        .b_i      (op_b),
        .hi_nxt_o (eng_hi),
        .lo_nxt_o (eng_lo),
        .last_o   (eng_last)
    );

    always_comb begin
        sc_res = '0;
        case (alu_op)
            ALU_AND: sc_res = op_a & op_b;
            ALU_OR:  sc_res = op_a | op_b;
            ALU_ADD: sc_res = op_a + op_b;
            ALU_SUB: sc_res = op_a - op_b;
            ALU_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_XOR: sc_res = op_a ^ op_b;
            ALU_SLL: sc_res = op_a << shamt;
            ALU_SRL: sc_res = op_a >> shamt;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        eng_load    = 1'b0;
        case (state_q)
            ITER: begin
                if (eng_last) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    result_d    = eng_lo;
                    result_hi_d = eng_hi;
                end
            end
            default: begin
                // DONE accepts exactly like IDLE so back-to-back ops lose no cycle.
                state_d = IDLE;
                if (start) begin
                    dbz_d = 1'b0;
                    case (alu_op)
                        ALU_MULT: begin
                            state_d  = ITER;
                            eng_load = 1'b1;
                        end
                        ALU_DIV: begin
                            if (op_b == '0) begin
                                state_d     = DONE;
                                done_d      = 1'b1;
                                result_d    = '1;
                                result_hi_d = op_a;
                                dbz_d       = 1'b1;
                            end else begin
                                state_d  = ITER;
                                eng_load = 1'b1;
                            end
                        end
                        default: begin
                            state_d     = DONE;
                            done_d      = 1'b1;
                            result_d    = sc_res;
                            result_hi_d = '0;
                        end
                    endcase
                end
            end
        endcase
        if (done_d) begin
            zero_d = (result_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign busy        = (state_q == ITER);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
